// File: rtl/divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, with a
// start/busy/valid handshake and a divide-by-zero shortcut straight to DONE.
`timescale 1ns/1ps

module divider #(
  parameter int N_W = 8,
  parameter int D_W = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [N_W-1:0] n_i,
  input  logic [D_W-1:0] d_i,
  output logic           busy_o,
  output logic           valid_o,
  output logic           dbz_o,
  output logic [N_W-1:0] quotient_o,
  output logic [D_W-1:0] remainder_o
);

  localparam int CNT_W = $clog2(N_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [N_W-1:0]   n_sh_q;
  logic [D_W-1:0]   d_q;
  logic [D_W-1:0]   r_q;
  logic [N_W-1:0]   q_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dbz_q;

  logic [D_W:0]     t_d;
  logic             qbit_d;
  logic [D_W-1:0]   r_d;

  // The partial remainder stays below the divisor, so its top bit is always 0
  // and is not stored; the trial value t is still formed D_W+1 bits wide.
  always_comb begin
    t_d    = {r_q, n_sh_q[N_W-1]};
    qbit_d = (t_d >= {1'b0, d_q});
    r_d    = t_d[D_W-1:0] - (qbit_d ? d_q : '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      n_sh_q  <= '0;
      d_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            n_sh_q  <= n_i;
            d_q     <= d_i;
            r_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= (d_i == '0);
            q_q     <= (d_i == '0) ? '1 : '0;
            state_q <= (d_i == '0) ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          r_q    <= r_d;
          n_sh_q <= n_sh_q << 1;
          q_q    <= {q_q[N_W-2:0], qbit_d};
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o      = (state_q == S_CALC);
    valid_o     = (state_q == S_DONE);
    dbz_o       = 1'b0;
    quotient_o  = '0;
    remainder_o = '0;
    if (state_q == S_DONE) begin
      dbz_o       = dbz_q;
      quotient_o  = q_q;
      remainder_o = r_q;
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed vectors, multi-cycle corner sequences and an exhaustive sweep for
// the 8-by-4 restoring divider.
`timescale 1ns/1ps

module tb_divider;

  localparam int N_W = 8;
  localparam int D_W = 4;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           start_i;
  logic [N_W-1:0] n_i;
  logic [D_W-1:0] d_i;
  logic           busy_o;
  logic           valid_o;
  logic           dbz_o;
  logic [N_W-1:0] quotient_o;
  logic [D_W-1:0] remainder_o;

  divider #(.N_W(N_W), .D_W(D_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .n_i         (n_i),
    .d_i         (d_i),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .dbz_o       (dbz_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o)
  );

  always #5 clk_i = ~clk_i;

  int vec_count = 0;
  int miss_count = 0;

  typedef struct {
    logic [N_W-1:0] n;
    logic [D_W-1:0] d;
    logic [N_W-1:0] q;
    logic [D_W-1:0] r;
    logic           dbz;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input int act, input int exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Accept one operation from IDLE/DONE, scramble operands afterwards and
  // check busy length, result and flags once valid_o rises.
  task automatic run_op(input logic [N_W-1:0] n, input logic [D_W-1:0] d,
                        input logic [N_W-1:0] eq, input logic [D_W-1:0] er,
                        input logic edbz, input string nm);
    int cyc;
    start_i = 1'b1;
    n_i     = n;
    d_i     = d;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n_i     = N_W'($urandom);
    d_i     = D_W'($urandom);
    cyc     = 0;
    while (busy_o && cyc < 20) begin
      check({nm, " valid_during_calc"}, int'(valid_o), 0);
      cyc++;
      @(posedge clk_i); #1;
      n_i = N_W'($urandom);
      d_i = D_W'($urandom);
    end
    check({nm, " busy_cycles"}, cyc, edbz ? 0 : N_W);
    check({nm, " valid"}, int'(valid_o), 1);
    check({nm, " busy_after"}, int'(busy_o), 0);
    check({nm, " dbz"}, int'(dbz_o), int'(edbz));
    check({nm, " quotient"}, int'(quotient_o), int'(eq));
    check({nm, " remainder"}, int'(remainder_o), int'(er));
    $display("op %s: n=%0d d=%0d -> q=%0d r=%0d dbz=%0d busy_cycles=%0d",
             nm, n, d, quotient_o, remainder_o, dbz_o, cyc);
  endtask

  initial begin
    int cur;
    int cyc;
    int blen;
    int overlap;
    int en;
    int ed;
    int exp_pack;
    int act_pack;
    bit accept;

    vecs[0] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0};
    vecs[1] = '{8'd5,   4'd15, 8'd0,   4'd5,  1'b0};
    vecs[2] = '{8'd37,  4'd0,  8'd255, 4'd0,  1'b1};
    vecs[3] = '{8'd100, 4'd10, 8'd10,  4'd0,  1'b0};
    vecs[4] = '{8'd0,   4'd3,  8'd0,   4'd0,  1'b0};
    vecs[5] = '{8'd254, 4'd15, 8'd16,  4'd14, 1'b0};
    vecs[6] = '{8'd1,   4'd1,  8'd1,   4'd0,  1'b0};
    vecs[7] = '{8'd7,   4'd8,  8'd0,   4'd7,  1'b0};
    vecs[8] = '{8'd255, 4'd0,  8'd255, 4'd0,  1'b1};

    rst_i   = 1'b1;
    start_i = 1'b0;
    n_i     = '0;
    d_i     = '0;
    #12;
    check("reset busy", int'(busy_o), 0);
    check("reset valid", int'(valid_o), 0);
    check("reset dbz", int'(dbz_o), 0);
    check("reset quotient", int'(quotient_o), 0);
    check("reset remainder", int'(remainder_o), 0);
    #1 rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("idle valid", int'(valid_o), 0);

    run_op(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, "n200_d7");
    repeat (3) @(posedge clk_i);
    #1;
    check("hold valid", int'(valid_o), 1);
    check("hold quotient", int'(quotient_o), 28);
    check("hold remainder", int'(remainder_o), 4);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].r, vecs[i].dbz,
             $sformatf("vec%0d", i));
    end

    // start_i and operands toggled during CALC must not disturb the result.
    start_i = 1'b1;
    n_i     = 8'd99;
    d_i     = 4'd4;
    @(posedge clk_i); #1;
    for (int i = 1; i <= N_W; i++) begin
      start_i = (i == 3);
      n_i     = (i == 3) ? 8'd1 : N_W'($urandom);
      d_i     = (i == 3) ? 4'd1 : D_W'($urandom);
      @(posedge clk_i); #1;
      if (i < N_W) check($sformatf("ignore busy c%0d", i), int'(busy_o), 1);
    end
    start_i = 1'b0;
    check("ignore valid", int'(valid_o), 1);
    check("ignore quotient", int'(quotient_o), 24);
    check("ignore remainder", int'(remainder_o), 3);
    $display("op ignore_start: n=99 d=4 -> q=%0d r=%0d", quotient_o, remainder_o);

    // Asynchronous reset between edges in CALC cycle 5.
    start_i = 1'b1;
    n_i     = 8'd200;
    d_i     = 4'd7;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    check("pre_reset busy", int'(busy_o), 1);
    #2 rst_i = 1'b1;
    #1;
    check("async_reset busy", int'(busy_o), 0);
    check("async_reset valid", int'(valid_o), 0);
    start_i = 1'b1;
    n_i     = 8'd144;
    d_i     = 4'd12;
    @(posedge clk_i); #1;
    check("start_in_reset busy", int'(busy_o), 0);
    check("start_in_reset valid", int'(valid_o), 0);
    #2 rst_i = 1'b0;
    start_i = 1'b0;
    $display("op async_reset: outputs cleared, start ignored while in reset");
    run_op(8'd144, 4'd12, 8'd12, 4'd0, 1'b0, "n144_d12");

    // Exhaustive sweep with start_i held high; op k uses n=k>>4, d=k&15.
    start_i = 1'b1;
    n_i     = 8'd0;
    d_i     = 4'd0;
    @(posedge clk_i); #1;
    n_i     = 8'd0;
    d_i     = 4'd1;
    cur     = 0;
    cyc     = 0;
    blen    = 0;
    overlap = 0;
    while (cur < 4096 && cyc < 50000) begin
      if (busy_o && valid_o) overlap++;
      if (busy_o) blen++;
      accept = 1'b0;
      if (valid_o) begin
        en = cur >> 4;
        ed = cur & 15;
        if (ed == 0) exp_pack = (0 << 16) | (1 << 12) | (255 << 4);
        else         exp_pack = (N_W << 16) | ((en / ed) << 4) | (en % ed);
        act_pack = (blen << 16) | (int'(dbz_o) << 12) | (int'(quotient_o) << 4)
                   | int'(remainder_o);
        check($sformatf("sweep n=%0d d=%0d {busy,dbz,q,r}", en, ed), act_pack, exp_pack);
        $display("op sweep: n=%0d d=%0d -> q=%0d r=%0d dbz=%0d busy_cycles=%0d",
                 en, ed, quotient_o, remainder_o, dbz_o, blen);
        cur++;
        blen   = 0;
        accept = 1'b1;
      end
      @(posedge clk_i); #1;
      cyc++;
      if (accept) begin
        if (cur + 1 < 4096) begin
          n_i = N_W'((cur + 1) >> 4);
          d_i = D_W'((cur + 1) & 15);
        end else begin
          start_i = 1'b0;
        end
      end
    end
    start_i = 1'b0;
    check("sweep ops_completed", cur, 4096);
    check("sweep busy_valid_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/divider.md
# divider

Sequential restoring divider. It uses the same start/busy/valid handshake as the shift-add multiplier and performs the inverse arithmetic. It divides an N_W-bit unsigned dividend by a D_W-bit unsigned divisor and produces one quotient bit per clock, MSB first. It returns the quotient, the remainder and a divide-by-zero flag. It sits beside the multiplier in the arithmetic datapath and is driven by the same controller.

## Interface
- N_W, 8, dividend and quotient width (≥ 2)
- D_W, 4, divisor and remainder width (≥ 1, ≤ N_W)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  request; sampled at rising edge in IDLE or DONE only
- n_i  in  N_W  dividend, unsigned; sampled with accepted start_i
- d_i  in  D_W  divisor, unsigned; sampled with accepted start_i
- busy_o  out  1  high while in CALC
- valid_o  out  1  high while in DONE; results meaningful only then
- dbz_o  out  1  divide-by-zero flag; meaningful only while valid_o
- quotient_o  out  N_W  quotient
- remainder_o  out  D_W  remainder

## Operation
- States:
  - IDLE: reset state, waiting for the first request.
  - CALC: iterating.
  - DONE: result held.
- Transitions:
  - IDLE → CALC on start_i=1 with d_i≠0.
  - IDLE → DONE on start_i=1 with d_i=0 (divide by zero).
  - CALC → DONE after the N_W-th iteration.
  - DONE → CALC or DONE on start_i=1, using the same rule as IDLE.
  - DONE → DONE otherwise.
  - No other transitions exist. An illegal encoding returns to IDLE.
- Accept (start_i=1 in IDLE or DONE):
  - Latch n_i into the dividend shift register and d_i into the divisor register.
  - Clear the partial remainder (D_W+1 bits), the quotient register and the iteration counter.
  - Set the dbz register to (d_i==0).
- Iteration (each CALC cycle):
  - t = {r[D_W-1:0], n_sh[N_W-1]}, computed D_W+1 bits wide; it cannot overflow.
  - If t ≥ {1'b0,d}, then r ← t − d and qbit=1; otherwise r ← t and qbit=0.
  - n_sh ← n_sh << 1.
  - q ← {q[N_W-2:0], qbit}.
  - Counter increments. Counter width is $clog2(N_W+1).
- After N_W iterations, quotient = q and remainder = r[D_W-1:0]. The invariant r < d holds every cycle, so r[D_W] is 0 at completion.
- Divide by zero: no CALC cycles are run. DONE is entered with:
  - quotient_o = all ones
  - remainder_o = 0
  - dbz_o = 1
- start_i is ignored in CALC. Operands n_i and d_i may change freely after the accept edge.
- Output muxing:
  - quotient_o, remainder_o and dbz_o are driven from registers when in DONE.
  - They are forced to 0 in IDLE and CALC.
  - They hold stable for the whole stay in DONE.

## Timing
- Reset values: state IDLE; busy_o=0, valid_o=0, dbz_o=0, quotient_o=0, remainder_o=0; all internal registers 0.
- All outputs are registered-state functions, with no combinational path from the inputs.
- Normal latency, with the accept at edge E:
  - busy_o is high from E to E+N_W (N_W cycles).
  - valid_o rises at edge E+N_W.
  - For N_W=8, the result is visible 8 cycles after accept.
- Divide-by-zero latency: valid_o and dbz_o rise at edge E, and busy_o never asserts.
- Back-to-back from DONE:
  - start_i at edge E causes valid_o to fall and busy_o to rise at E.
  - The new result appears at E+N_W.
  - There is no mandatory idle cycle between operations.
- start_i held high continuously: each completion re-accepts on the first DONE cycle's edge. valid_o is therefore high for exactly 1 cycle per operation.
- Reset mid-operation:
  - Asserting rst_i in any state immediately forces all outputs to their reset values and the state to IDLE.
  - The in-flight result is discarded.
  - start_i is not accepted while rst_i is high.
- busy_o and valid_o are never high simultaneously.

## Test plan
- Reset then n=200, d=7 → busy_o high 8 cycles; then valid_o=1, quotient_o=28, remainder_o=4, dbz_o=0; held until next start.
- n=255, d=1 → quotient_o=255, remainder_o=0. Then n=5, d=15 → quotient_o=0, remainder_o=5. Both run back-to-back from DONE with no idle cycle.
- n=37, d=0 → valid_o and dbz_o at the accept edge, busy_o never high, quotient_o=255, remainder_o=0. A following n=100, d=10 gives quotient_o=10, remainder_o=0, dbz_o=0.
- Start n=99, d=4; pulse start_i with n=1, d=1 in CALC cycle 3 and change n_i/d_i every cycle → result unaffected: quotient_o=24, remainder_o=3 at cycle 8.
- Assert rst_i asynchronously (between edges) in CALC cycle 5 → outputs 0 and IDLE immediately. A new start with n=144, d=12 then gives quotient_o=12, remainder_o=0.
- Exhaustive sweep of all 4096 (n, d) pairs against a reference model, with start_i held high → every result matches n/d and n%d, valid_o pulses exactly once per operation, and busy_o and valid_o are never both high.
